// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and the stereo sample payload for the I2S transmit path.
//   I2S_FRAME_BITS  - bits per stereo frame word (L + R)
//   I2S_SAMPLE_BITS - bits per channel sample
//   I2S_VOL_BITS    - width of the volume control
//   i2s_sample_t    - packed {l, r} signed sample pair, l in the upper half
package i2s_pkg;

    localparam int unsigned I2S_FRAME_BITS  = 32;
    localparam int unsigned I2S_SAMPLE_BITS = 16;
    localparam int unsigned I2S_VOL_BITS    = 8;

    typedef struct packed {
        logic signed [I2S_SAMPLE_BITS-1:0] l;
        logic signed [I2S_SAMPLE_BITS-1:0] r;
    } i2s_sample_t;

endpackage

// File: rtl/i2s_tx_ser_if.sv
// i2s_tx_ser_if: valid/ready sample stream into the I2S serialiser.
//   s_tdata  - {L[15:0], R[15:0]} sample word
//   s_tvalid - s_tdata is valid
//   s_tready - serialiser holding register is empty
//   master   - sample producer (fetch/DMA path)
//   slave    - the serialiser
interface i2s_tx_ser_if;
    import i2s_pkg::*;

    logic [I2S_FRAME_BITS-1:0] s_tdata;
    logic                      s_tvalid;
    logic                      s_tready;

    modport master (output s_tdata, output s_tvalid, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, output s_tready);

endinterface

// File: rtl/i2s_vol_scale.sv
// i2s_vol_scale: combinational per-channel gain of (volume+1)/256.
// Only built when I2S_TX_VOLUME_EN is defined.
//   sample   - signed 16-bit input sample
//   volume   - 8-bit gain code, 255 = unity
//   scaled_c - signed 16-bit result, floor(sample * (volume+1) / 256)
`ifdef I2S_TX_VOLUME_EN
module i2s_vol_scale
    import i2s_pkg::*;
(
    input  logic signed [I2S_SAMPLE_BITS-1:0] sample,
    input  logic        [I2S_VOL_BITS-1:0]    volume,
    output logic signed [I2S_SAMPLE_BITS-1:0] scaled_c
);

    localparam int unsigned GAIN_W = I2S_VOL_BITS + 1;
    localparam int unsigned PROD_W = I2S_SAMPLE_BITS + GAIN_W;

    logic [GAIN_W-1:0] gain;

    // volume+1 needs the ninth bit so that 255 maps to a gain of exactly 256
    assign gain = {1'b0, volume} + GAIN_W'(1);

    // Signed product, arithmetic shift floors toward -inf; |result| <= |sample| so 16 bits suffice
    assign scaled_c = I2S_SAMPLE_BITS'((PROD_W'(sample) * PROD_W'($signed({1'b0, gain}))) >>> I2S_VOL_BITS);

endmodule
`endif

// File: rtl/i2s_tx_ser.sv
// i2s_tx_ser: serialises stereo 16-bit PCM words into a Philips I2S stream.
// Optional feature macro: I2S_TX_VOLUME_EN (volume scaling at accept time).
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset
//   en       - serialiser enable; deassertion parks the bit clock and frame position
//   s        - sample stream slave (s_tdata / s_tvalid / s_tready)
//   volume   - gain code sampled at accept, (volume+1)/256
//   underrun - one-cycle pulse when a frame starts with no sample held
//   i2s_bclk - bit clock, period 2*CLK_DIV clk cycles
//   i2s_wclk - word select, 0 = Left, 1 = Right
//   i2s_dout - serial data, MSB first, one bit after each word select edge
module i2s_tx_ser
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    i2s_tx_ser_if.slave             s,
    input  logic [I2S_VOL_BITS-1:0] volume,
    output logic                    underrun,
    output logic                    i2s_bclk,
    output logic                    i2s_wclk,
    output logic                    i2s_dout
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned POS_W = $clog2(I2S_FRAME_BITS);

    logic [DIV_W-1:0]          div_q, div_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic                      bclk_q, bclk_d;
    logic                      wclk_q, wclk_d;
    logic                      dout_q, dout_d;
    logic [I2S_FRAME_BITS-1:0] shift_q, shift_d;
    i2s_sample_t               hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic                      tready_q, tready_d;
    logic                      underrun_q, underrun_d;
    logic                      accept_c;
    i2s_sample_t               scaled_c;

    // Sample conditioning ahead of the holding register
`ifdef I2S_TX_VOLUME_EN
    logic signed [I2S_SAMPLE_BITS-1:0] scaled_l_c;
    logic signed [I2S_SAMPLE_BITS-1:0] scaled_r_c;

    i2s_vol_scale u_vol_l (
        .sample   (s.s_tdata[I2S_FRAME_BITS-1:I2S_SAMPLE_BITS]),
        .volume   (volume),
        .scaled_c (scaled_l_c)
    );

    i2s_vol_scale u_vol_r (
        .sample   (s.s_tdata[I2S_SAMPLE_BITS-1:0]),
        .volume   (volume),
        .scaled_c (scaled_r_c)
    );

    assign scaled_c = {scaled_l_c, scaled_r_c};
`else
    logic unused_volume;
    assign unused_volume = ^volume;
    assign scaled_c      = s.s_tdata;
`endif

    // Divider, frame sequencing, shifter and holding-register next state
    always_comb begin
        div_d       = div_q;
        pos_d       = pos_q;
        bclk_d      = bclk_q;
        wclk_d      = wclk_q;
        dout_d      = dout_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        accept_c    = s.s_tvalid & tready_q;

        if (!en) begin
            div_d   = '0;
            pos_d   = '0;
            bclk_d  = 1'b0;
            wclk_d  = 1'b0;
            dout_d  = 1'b0;
            shift_d = '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            // Everything serial moves on the falling bit-clock edge
            if (bclk_q) begin
                pos_d  = pos_q + POS_W'(1);
                wclk_d = pos_d[POS_W-1];
                // Load at p=1 so the MSB trails the word-select edge by one bit
                if (pos_d == POS_W'(1)) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d    = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    shift_d = shift_q << 1;
                end
                dout_d = shift_d[I2S_FRAME_BITS-1];
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Accept only when empty, so it never collides with a load of valid data
        if (accept_c) begin
            hold_d      = scaled_c;
            hold_full_d = 1'b1;
        end

        tready_d = ~hold_full_d;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            pos_q       <= '0;
            bclk_q      <= 1'b0;
            wclk_q      <= 1'b0;
            dout_q      <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tready_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            pos_q       <= pos_d;
            bclk_q      <= bclk_d;
            wclk_q      <= wclk_d;
            dout_q      <= dout_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tready_q    <= tready_d;
            underrun_q  <= underrun_d;
        end
    end

    assign s.s_tready = tready_q;
    assign underrun   = underrun_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_wclk   = wclk_q;
    assign i2s_dout   = dout_q;

endmodule

// File: tb/tb_i2s_tx_ser.sv
// tb_i2s_tx_ser: randomized self-checking bench for i2s_tx_ser with an I2S receiver model.
module tb_i2s_tx_ser;

    localparam int unsigned CLK_DIV   = 4;
    localparam int          FRAME_CYC = 64 * CLK_DIV;
`ifdef I2S_TX_VOLUME_EN
    localparam bit VOL_EN = 1'b1;
`else
    localparam bit VOL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] volume;
    logic       underrun;
    logic       i2s_bclk;
    logic       i2s_wclk;
    logic       i2s_dout;

    always #5 clk = ~clk;

    i2s_tx_ser_if sif ();

    i2s_tx_ser #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .s        (sif),
        .volume   (volume),
        .underrun (underrun),
        .i2s_bclk (i2s_bclk),
        .i2s_wclk (i2s_wclk),
        .i2s_dout (i2s_dout)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference gain: floor(s * g / 256), g = volume+1 or unity when scaling is absent
    function automatic logic [15:0] scale_ch(input logic [15:0] smp, input logic [7:0] v);
        int g;
        int p;
        int q;
        g = VOL_EN ? int'(v) + 1 : 256;
        p = int'($signed(smp)) * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return 16'(q);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] w, input logic [7:0] v);
        return {scale_ch(w[31:16], v), scale_ch(w[15:0], v)};
    endfunction

    // Receiver: samples DOUT on BCLK rise; a word-select change closes the previous word
    int          cyc     = 0;
    int          toggles = 0;
    int          un_cnt  = 0;
    int          un_times[$];
    logic [31:0] rx_q[$];

    initial begin
        logic        pb;
        logic        pw;
        logic        last_bclk;
        logic [31:0] sreg;
        logic [15:0] rx_l;
        pb = 1'b0; pw = 1'b0; last_bclk = 1'b0; sreg = '0; rx_l = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i2s_bclk != last_bclk) toggles++;
            last_bclk = i2s_bclk;
            if (underrun === 1'b1) begin
                un_cnt++;
                un_times.push_back(cyc);
            end
            if (en !== 1'b1) begin
                pb = 1'b0;
                pw = 1'b0;
            end else begin
                if (i2s_bclk && !pb) begin
                    sreg = {sreg[30:0], i2s_dout};
                    if (i2s_wclk != pw) begin
                        if (!pw) rx_l = sreg[15:0];
                        else     rx_q.push_back({rx_l, sreg[15:0]});
                    end
                    pw = i2s_wclk;
                end
                pb = i2s_bclk;
            end
        end
    end

    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        sif.s_tdata  = w;
        sif.s_tvalid = 1'b1;
        while (!sif.s_tready && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(sif.s_tready), 32'd1);
        @(negedge clk);
        sif.s_tvalid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int k);
        int n;
        n = 0;
        while (rx_q.size() < k && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rx_q.size() >= k), 32'd1);
    endtask

    task automatic wait_tready(input string tag);
        int n;
        n = 0;
        while (!sif.s_tready && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sif.s_tready), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] w, input logic [7:0] v,
                           output logic [31:0] got);
        volume = v;
        push(w);
        rx_q.delete();
        en = 1'b1;
        wait_rx({tag, "_wait"}, 1);
        got = (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF;
        check(tag, got, model(w, v));
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w;
        logic [31:0] word_a;
        logic [31:0] word_b;
        logic [31:0] data;
        logic [31:0] exp_q[$];
        logic [7:0]  v;
        int          hs_t[$];
        int          base;
        bit          hs;
        int          n;

        reset = 1'b1; en = 1'b0; volume = 8'd255;
        sif.s_tvalid = 1'b0; sif.s_tdata = '0;

        // Reset and idle
        repeat (5) @(negedge clk);
        check("rst_outputs", 32'({underrun, i2s_bclk, i2s_wclk, i2s_dout}), 32'd0);
        check("rst_tready", 32'(sif.s_tready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_tready", 32'(sif.s_tready), 32'd1);
        repeat (20) @(negedge clk);
        check("idle_bclk_toggles", 32'(toggles), 32'd0);

        // Unity frame, extreme values exercise the sign bits
        run_one("unity_frame", 32'h8001_7FFE, 8'd255, got);
        check("unity_const", got, 32'h8001_7FFE);

`ifdef I2S_TX_VOLUME_EN
        run_one("vol127", 32'h4000_C000, 8'd127, got);
        check("vol127_const", got, 32'h2000_E000);
        run_one("vol0", 32'h0001_0001, 8'd0, got);
        check("vol0_const", got[31:16], 32'h0000);
`endif

        // Random words at random volume
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            v = 8'($urandom_range(0, 255));
            run_one("rand_frame", w, v, got);
        end

        // Underrun: three frames with nothing supplied
        rx_q.delete();
        un_times.delete();
        base = un_cnt;
        en   = 1'b1;
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("ur_count", 32'(un_cnt - base), 32'd3);
        for (int i = 0; i + 1 < un_times.size(); i++)
            check("ur_spacing", 32'(un_times[i+1] - un_times[i]), 32'(FRAME_CYC));
        check("ur_frames", 32'(rx_q.size()), 32'd2);
        foreach (rx_q[i]) check("ur_zero_data", rx_q[i], 32'd0);
        en = 1'b0;
        @(negedge clk);

        // Back-pressure: valid held high with an incrementing count
        v      = 8'($urandom_range(0, 255));
        volume = v;
        rx_q.delete();
        base = un_cnt;
        data = $urandom;
        sif.s_tdata  = data;
        sif.s_tvalid = 1'b1;
        en = 1'b1;
        hs = sif.s_tready;
        if (hs) begin
            exp_q.push_back(model(data, v));
            hs_t.push_back(0);
        end
        for (int i = 1; i <= 8 * FRAME_CYC + 300; i++) begin
            @(negedge clk);
            if (hs) begin
                data = data + 32'd1;
                sif.s_tdata = data;
            end
            hs = sif.s_tready;
            if (hs) begin
                exp_q.push_back(model(data, v));
                hs_t.push_back(i);
            end
        end
        sif.s_tvalid = 1'b0;
        check("bp_hs_count", 32'(hs_t.size()), 32'd11);
        for (int i = 1; i + 1 < hs_t.size(); i++)
            check("bp_hs_spacing", 32'(hs_t[i+1] - hs_t[i]), 32'(FRAME_CYC));
        check("bp_frames", 32'(rx_q.size() >= 8), 32'd1);
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check("bp_word", rx_q[i], exp_q[i]);
        check("bp_underrun", 32'(un_cnt - base), 32'd0);

        // Enable drop mid-Right with a second word held
        wait_tready("drop_drain");
        v      = 8'($urandom_range(0, 255));
        volume = v;
        word_a = $urandom;
        word_b = $urandom | 32'h0001_0001;
        push(word_a);
        wait_tready("drop_a_loaded");
        push(word_b);
        n = 0;
        while (!i2s_wclk && n < FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("drop_reach_right", 32'(i2s_wclk), 32'd1);
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drop_outputs", 32'({i2s_bclk, i2s_wclk, i2s_dout}), 32'd0);
        check("drop_hold_kept", 32'(sif.s_tready), 32'd0);
        repeat (10) @(negedge clk);
        check("drop_hold_still", 32'(sif.s_tready), 32'd0);
        rx_q.delete();
        base = un_cnt;
        en   = 1'b1;
        wait_rx("reen_wait", 1);
        check("reen_frame", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, model(word_b, v));
        check("reen_underrun", 32'(un_cnt - base), 32'd0);
        en = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx_ser.md
# i2s_tx_ser

Serialises stereo 16-bit PCM sample words into a standard Philips I2S bitstream (BCLK, WCLK, DOUT). It sits downstream of the r_i2s_apb DMA/sample fetch path, which feeds it one `{L,R}` word per frame over a valid/ready handshake. The block contains a one-entry holding register and optional volume scaling, and it reports underruns to the register block for interrupt and status use.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per BCLK half-period; legal range 1..255.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: serialiser enable.
- `s_tdata` in 32: sample word; `[31:16]` is signed Left, `[15:0]` is signed Right.
- `s_tvalid` in 1: `s_tdata` is valid.
- `s_tready` out 1: the holding register is empty.
- `volume` in 8: gain is (volume+1)/256; 255 gives unity gain.
- `underrun` out 1: one-cycle pulse when a frame starts with no sample held.
- `i2s_bclk` out 1: bit clock.
- `i2s_wclk` out 1: word select; 0 = Left, 1 = Right.
- `i2s_dout` out 1: serial data, MSB first.

## Operation
- **Reset values:** `i2s_bclk`=0, `i2s_wclk`=0, `i2s_dout`=0, `underrun`=0, `s_tready`=0. Internally: `div`=0, frame position `p`=0, hold register empty, shifter=0.
- **Ready:** `s_tready` = `!hold_full` while not in reset, independent of `en`.
- **Accept:** when `s_tvalid & s_tready`, the hold register takes the scaled sample and `hold_full` is set.
- **Divider:** while `en`=1, `div` counts 0..CLK_DIV-1. At terminal count, `div` returns to 0 and BCLK toggles.
- **Falling BCLK edge** (BCLK 1→0): `p` advances `(p+1) mod 32`, shifter shifts left by one, and `i2s_dout` = shifter MSB after the update.
- **WCLK:** `i2s_wclk` = `p[4]` of the new `p`.
- **Frame load:** occurs on the falling edge that makes `p`=1.
  - If `hold_full`: shifter ← hold, `hold_full` cleared. `i2s_dout` = L[15] at `p`=1, so data lags WCLK by one bit, per I2S.
  - Else: shifter ← 0 and `underrun` pulses for exactly that cycle.
- **End of frame:** at `p`=0, `i2s_dout` still carries the previous frame's R[0].
- **Simultaneous accept and load:** the load consumes the old hold contents. The accept is impossible in that cycle because `s_tready` was 0, so no sample is lost.
- **`en` deasserted:** in the next cycle `div`, `p`, BCLK, WCLK, DOUT and the shifter go to 0. `hold_full` is retained. On re-enable, the first falling edge loads the frame at `p`=1.
- **Volume arithmetic:** per channel, result = `(s16 × unsigned9(volume+1)) >>> 8`. This is a 25-bit signed product with an arithmetic shift, so it truncates toward −∞; the low 16 bits are kept and cannot overflow. `volume` is sampled at accept time, not at frame load.

## Timing
- BCLK period = 2·CLK_DIV `clk` cycles; frame = 64·CLK_DIV cycles. Sample rate = f_clk / (64·CLK_DIV).
- All outputs are registered. DOUT and WCLK change in the same cycle as BCLK falls; the receiver samples on the BCLK rising edge, CLK_DIV cycles later.
- Accept-to-hold latency: 1 cycle. Hold-to-first-bit: up to one frame.
- `s_tready` reasserts the cycle after a frame load.
- Steady state: one handshake per 64·CLK_DIV cycles.

## Configuration
- `I2S_TX_VOLUME_EN` defined: the multiplier is present and volume scaling is applied as described.
- Not defined: `volume` is ignored, the hold register takes `s_tdata` unmodified, and no multiplier is synthesised.

## Structure
- Shared package `i2s_pkg`:
  - `I2S_FRAME_BITS`=32 and `I2S_SAMPLE_BITS`=16.
  - The stereo sample struct `{logic signed [15:0] l, r}`.
  - The volume width `I2S_VOL_BITS`=8.
- One sub-module, `i2s_vol_scale`: combinational per-channel scaler instantiated twice. It is only present under `I2S_TX_VOLUME_EN`.

## Test plan
1. **Reset/idle:** hold `reset` 5 cycles with `en`=0. Outputs must all be 0 and `s_tready`=0 in reset, then `s_tready`=1. BCLK must not toggle.
2. **Unity frame:** CLK_DIV=4, `volume`=255, push 0x8001_7FFE, `en`=1. Sampling DOUT on BCLK rising edges must decode L=0x8001 (WCLK=0) and R=0x7FFE (WCLK=1), with the MSB one bit after each WCLK transition.
3. **Volume (macro defined):** `volume`=127, push L=0x4000, R=0xC000. Output must be L=0x2000, R=0xE000. With `volume`=0 and L=0x0001, L must be 0x0000.
4. **Underrun:** `en`=1 with `s_tvalid`=0 for 3 frames. DOUT must be all zeros and `underrun` must pulse exactly 3 times, 256 cycles apart at CLK_DIV=4.
5. **Back-pressure:** hold `s_tvalid`=1 with an incrementing count. There must be exactly one handshake per 256 cycles, no word may be skipped or duplicated across 8 frames, and `underrun` must stay 0.
6. **Enable drop:** deassert `en` mid-Right channel. BCLK, WCLK and DOUT must be 0 the next cycle and `hold_full` retained. On re-enable, that held word must be the first frame output.
